// File: rtl/psram_req_sched_pkg.sv
// Shared types for the PSRAM request scheduler.
//   sched_state_e : scheduler FSM states (2 bit)
//   req_id_e      : requester identity of the transaction in flight
package psram_req_sched_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StBusy  = 2'd2,
    StGap   = 2'd3
  } sched_state_e;

  typedef enum logic [1:0] {
    ReqCfg = 2'd0,
    ReqWr  = 2'd1,
    ReqRd  = 2'd2
  } req_id_e;

  localparam int unsigned DataW = 32;
  localparam int unsigned CfgW  = 8;

endpackage

// File: rtl/psram_req_sched_rr_arb2.sv
// Two-way round-robin arbiter with gated pointer update.
//   clk_i, rst_n_i : clock, synchronous active-low reset
//   req_i[1:0]     : requests (0 = write path, 1 = read path)
//   upd_i          : advance the pointer past the current winner
//   gnt_o[1:0]     : combinational one-hot grant
// After reset the write path (index 0) has priority.
module psram_req_sched_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    if (!ptr_q) begin
      if (req_i[0])      gnt_o = 2'b01;
      else if (req_i[1]) gnt_o = 2'b10;
    end else begin
      if (req_i[1])      gnt_o = 2'b10;
      else if (req_i[0]) gnt_o = 2'b01;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (upd_i) begin
      if (gnt_o[0])      ptr_d = 1'b1;
      else if (gnt_o[1]) ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) ptr_q <= 1'b0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/psram_req_sched.sv
// PSRAM request scheduler: serialises cfg / AXI-write / AXI-read transactions onto psram_core.
// cfg has strict priority, write and read share a round-robin slot. One transaction at a time:
// IDLE -> ISSUE (start + grant) -> BUSY (wait core done) -> GAP (MIN_GAP idle cycles) -> IDLE.
// Ports: cfg_* / wr_* / rd_* requester handshakes, core_* launch interface toward psram_core,
// busy_o (state != IDLE), err_o (sticky timeout).
// Optional feature: define PSRAM_SCHED_TMO_EN to abort a BUSY transaction after TMO_CYC cycles
// (owner gets a done pulse with zero data, err_o sets). Without it err_o is tied low.
module psram_req_sched
  import psram_req_sched_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 24,
  parameter int unsigned MIN_GAP    = 4,
  parameter int unsigned TMO_CYC    = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic                  cfg_req_i,
  input  logic                  cfg_we_i,
  input  logic [CfgW-1:0]       cfg_ma_i,
  input  logic [CfgW-1:0]       cfg_wdat_i,
  output logic                  cfg_gnt_o,
  output logic                  cfg_done_o,
  output logic [CfgW-1:0]       cfg_rdat_o,
  input  logic                  wr_req_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DataW-1:0]      wr_dat_i,
  output logic                  wr_gnt_o,
  output logic                  wr_done_o,
  input  logic                  rd_req_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic                  rd_gnt_o,
  output logic                  rd_done_o,
  output logic [DataW-1:0]      rd_dat_o,
  output logic                  core_start_o,
  output logic                  core_cflg_o,
  output logic                  core_wr_o,
  output logic [ADDR_WIDTH-1:0] core_addr_o,
  output logic [DataW-1:0]      core_wdat_o,
  input  logic                  core_done_i,
  input  logic [DataW-1:0]      core_rdat_i,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int unsigned GapW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

  sched_state_e          state_q, state_d;
  req_id_e               owner_q, owner_d;
  logic                  cflg_q, cflg_d, wr_q, wr_d, done_q, done_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DataW-1:0]      wdat_q, wdat_d, rd_dat_q, rd_dat_d;
  logic [CfgW-1:0]       cfg_rdat_q, cfg_rdat_d;
  logic [GapW-1:0]       gap_cnt_q, gap_cnt_d;

  logic       launch, tmo_fire, cap;
  logic [1:0] arb_gnt;
  logic [DataW-1:0] cap_dat;

  // Arbitration is only evaluated in IDLE; a cfg win must not disturb the wr/rd pointer.
  assign launch = (state_q == StIdle) && en_i && (cfg_req_i || wr_req_i || rd_req_i);

  psram_req_sched_rr_arb2 u_arb (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .req_i   ({rd_req_i, wr_req_i}),
    .upd_i   (launch && !cfg_req_i),
    .gnt_o   (arb_gnt)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cflg_d     = cflg_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdat_d     = wdat_q;
    rd_dat_d   = rd_dat_q;
    cfg_rdat_d = cfg_rdat_q;
    done_d     = 1'b0;
    gap_cnt_d  = '0;
    cap        = 1'b0;
    cap_dat    = '0;
    unique case (state_q)
      StIdle: begin
        if (launch) begin
          state_d = StIssue;
          if (cfg_req_i) begin
            owner_d = ReqCfg;
            cflg_d  = 1'b1;
            wr_d    = cfg_we_i;
            addr_d  = ADDR_WIDTH'(cfg_ma_i);
            wdat_d  = {24'd0, cfg_wdat_i};
          end else if (arb_gnt[0]) begin
            owner_d = ReqWr;
            cflg_d  = 1'b0;
            wr_d    = 1'b1;
            addr_d  = wr_addr_i;
            wdat_d  = wr_dat_i;
          end else begin
            owner_d = ReqRd;
            cflg_d  = 1'b0;
            wr_d    = 1'b0;
            addr_d  = rd_addr_i;
            wdat_d  = '0;
          end
        end
      end
      StIssue: state_d = StBusy;
      StBusy: begin
        if (core_done_i) begin
          cap     = 1'b1;
          cap_dat = core_rdat_i;
        end else if (tmo_fire) begin
          cap = 1'b1;
        end
      end
      StGap: begin
        if (int'(gap_cnt_q) + 1 >= int'(MIN_GAP)) state_d = StIdle;
        else gap_cnt_d = gap_cnt_q + GapW'(1);
      end
      default: state_d = StIdle;
    endcase
    // Completion (normal or aborted): registered done pulse, capture read data for the owner.
    if (cap) begin
      done_d  = 1'b1;
      state_d = (MIN_GAP == 0) ? StIdle : StGap;
      if (owner_q == ReqCfg) cfg_rdat_d = cap_dat[CfgW-1:0];
      if (owner_q == ReqRd)  rd_dat_d   = cap_dat;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= StIdle;
      owner_q    <= ReqCfg;
      cflg_q     <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdat_q     <= '0;
      rd_dat_q   <= '0;
      cfg_rdat_q <= '0;
      done_q     <= 1'b0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cflg_q     <= cflg_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdat_q     <= wdat_d;
      rd_dat_q   <= rd_dat_d;
      cfg_rdat_q <= cfg_rdat_d;
      done_q     <= done_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

`ifdef PSRAM_SCHED_TMO_EN
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        err_q, err_d;

  // Counter is cleared outside BUSY, so it restarts from zero for every transaction.
  assign tmo_fire  = (state_q == StBusy) && !core_done_i && (tmo_cnt_q == 16'(TMO_CYC - 1));
  assign tmo_cnt_d = (state_q == StBusy) ? tmo_cnt_q + 16'd1 : 16'd0;
  assign err_d     = err_q || tmo_fire;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  assign err_o = err_q;
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO_CYC;
  assign tmo_fire   = 1'b0;
  assign err_o      = 1'b0;
`endif

  assign core_start_o = (state_q == StIssue);
  assign cfg_gnt_o    = core_start_o && (owner_q == ReqCfg);
  assign wr_gnt_o     = core_start_o && (owner_q == ReqWr);
  assign rd_gnt_o     = core_start_o && (owner_q == ReqRd);
  assign cfg_done_o   = done_q && (owner_q == ReqCfg);
  assign wr_done_o    = done_q && (owner_q == ReqWr);
  assign rd_done_o    = done_q && (owner_q == ReqRd);
  assign cfg_rdat_o   = cfg_rdat_q;
  assign rd_dat_o     = rd_dat_q;
  assign core_cflg_o  = cflg_q;
  assign core_wr_o    = wr_q;
  assign core_addr_o  = addr_q;
  assign core_wdat_o  = wdat_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_psram_req_sched.sv
module tb_psram_req_sched;

  localparam int unsigned AW = 24;
  localparam int unsigned MG = 4;
  localparam int unsigned TC = 16;
  localparam logic [1:0] OwnRd = 2'd0, OwnWr = 2'd1, OwnCfg = 2'd2;

  logic          clk = 1'b0;
  logic          rst_n, en;
  logic          cfg_req, cfg_we;
  logic [7:0]    cfg_ma, cfg_wdat, cfg_rdat;
  logic          cfg_gnt, cfg_done;
  logic          wr_req, rd_req, wr_gnt, rd_gnt, wr_done, rd_done;
  logic [AW-1:0] wr_addr, rd_addr, core_addr;
  logic [31:0]   wr_dat, rd_dat, core_wdat, core_rdat;
  logic          core_start, core_cflg, core_wr, core_done;
  logic          busy, err;

  always #5 clk = ~clk;

  psram_req_sched #(
    .ADDR_WIDTH (AW),
    .MIN_GAP    (MG),
    .TMO_CYC    (TC)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .en_i         (en),
    .cfg_req_i    (cfg_req),
    .cfg_we_i     (cfg_we),
    .cfg_ma_i     (cfg_ma),
    .cfg_wdat_i   (cfg_wdat),
    .cfg_gnt_o    (cfg_gnt),
    .cfg_done_o   (cfg_done),
    .cfg_rdat_o   (cfg_rdat),
    .wr_req_i     (wr_req),
    .wr_addr_i    (wr_addr),
    .wr_dat_i     (wr_dat),
    .wr_gnt_o     (wr_gnt),
    .wr_done_o    (wr_done),
    .rd_req_i     (rd_req),
    .rd_addr_i    (rd_addr),
    .rd_gnt_o     (rd_gnt),
    .rd_done_o    (rd_done),
    .rd_dat_o     (rd_dat),
    .core_start_o (core_start),
    .core_cflg_o  (core_cflg),
    .core_wr_o    (core_wr),
    .core_addr_o  (core_addr),
    .core_wdat_o  (core_wdat),
    .core_done_i  (core_done),
    .core_rdat_i  (core_rdat),
    .busy_o       (busy),
    .err_o        (err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int last_done_cyc = 0;

  typedef struct {
    logic [1:0]    owner;
    logic          cflg;
    logic          wr;
    logic [AW-1:0] addr;
    logic [31:0]   wdat;
  } exp_t;
  exp_t sbq[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [1:0] o, input logic c, input logic w,
                      input logic [AW-1:0] a, input logic [31:0] d);
    exp_t e;
    e.owner = o; e.cflg = c; e.wr = w; e.addr = a; e.wdat = d;
    sbq.push_back(e);
  endtask

  task automatic wait_start();
    int n = 0;
    while (!core_start && n < 60) begin
      tick();
      n++;
    end
    check("start_seen", 64'(core_start), 64'd1);
  endtask

  // One transaction from launch to done: scoreboard compare at start, done/data compare after.
  // drop = {cfg,wr,rd} requests to release at grant.
  task automatic run_txn(input logic [31:0] rdat, input int busy_n, input logic [2:0] drop,
                         input bit chk_gap, input bit en_off);
    exp_t e;
    logic [2:0] oh;
    wait_start();
    if (chk_gap) check("start_gap", 64'(cyc - last_done_cyc), 64'(MG + 2));
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty: observed=start expected=no_start");
      return;
    end
    e  = sbq.pop_front();
    oh = 3'b001 << e.owner;
    check("gnt_vec",   64'({cfg_gnt, wr_gnt, rd_gnt}), 64'(oh));
    check("core_cflg", 64'(core_cflg), 64'(e.cflg));
    check("core_wr",   64'(core_wr),   64'(e.wr));
    check("core_addr", 64'(core_addr), 64'(e.addr));
    check("core_wdat", 64'(core_wdat), 64'(e.wdat));
    if (drop[2]) cfg_req = 1'b0;
    if (drop[1]) wr_req  = 1'b0;
    if (drop[0]) rd_req  = 1'b0;
    if (en_off)  en      = 1'b0;
    tick();
    check("gnt_1cyc", 64'({core_start, cfg_gnt, wr_gnt, rd_gnt, busy}), 64'h1);
    repeat (busy_n) tick();
    check("no_early_done", 64'({cfg_done, wr_done, rd_done}), 64'd0);
    core_done = 1'b1;
    core_rdat = rdat;
    last_done_cyc = cyc;
    tick();
    core_done = 1'b0;
    core_rdat = 32'h0BAD_F00D;
    check("done_vec", 64'({cfg_done, wr_done, rd_done}), 64'(oh));
    if (e.owner == OwnRd)              check("rd_dat", 64'(rd_dat), 64'(rdat));
    if (e.owner == OwnCfg && !e.wr)    check("cfg_rdat", 64'(cfg_rdat), 64'(rdat[7:0]));
    tick();
    check("done_1cyc", 64'({cfg_done, wr_done, rd_done}), 64'd0);
  endtask

  initial begin
    int n;
    logic acc;
    exp_t e;
    rst_n = 1'b0; en = 1'b0;
    cfg_req = 1'b0; cfg_we = 1'b0; cfg_ma = '0; cfg_wdat = '0;
    wr_req = 1'b0; rd_req = 1'b0; wr_addr = '0; rd_addr = '0; wr_dat = '0;
    core_done = 1'b0; core_rdat = '0;
    repeat (3) tick();
    check("rst_ctrl", 64'({cfg_gnt, cfg_done, wr_gnt, rd_gnt, wr_done, rd_done, core_start,
                           core_cflg, core_wr, busy, err}), 64'd0);
    check("rst_cfg_rdat", 64'(cfg_rdat), 64'd0);
    check("rst_rd_dat", 64'(rd_dat), 64'd0);
    check("rst_core_bus", 64'({core_addr, core_wdat}), 64'd0);
    rst_n = 1'b1; en = 1'b1;
    tick();

    // cfg write alone: grant + start one cycle after the request is seen
    cfg_req = 1'b1; cfg_we = 1'b1; cfg_ma = 8'h04; cfg_wdat = 8'h8F;
    push(OwnCfg, 1'b1, 1'b1, 24'h000004, 32'h0000008F);
    tick();
    check("cfg_latency", 64'({core_start, cfg_gnt}), 64'h3);
    run_txn(32'h0, 3, 3'b100, 1'b0, 1'b0);

    // wr and rd held together: alternation, exact gap after each done
    wr_req = 1'b1; wr_addr = 24'h000200; wr_dat = 32'h11223344;
    rd_req = 1'b1; rd_addr = 24'h000300;
    push(OwnWr, 1'b0, 1'b1, 24'h000200, 32'h11223344);
    push(OwnRd, 1'b0, 1'b0, 24'h000300, 32'h0);
    push(OwnWr, 1'b0, 1'b1, 24'h000200, 32'h11223344);
    push(OwnRd, 1'b0, 1'b0, 24'h000300, 32'h0);
    run_txn(32'h0,        2, 3'b000, 1'b0, 1'b0);
    run_txn(32'hA1A2A3A4, 1, 3'b000, 1'b1, 1'b0);
    run_txn(32'h0,        4, 3'b000, 1'b1, 1'b0);
    run_txn(32'h5A5A0001, 2, 3'b011, 1'b1, 1'b0);

    // single read returns core data; wr_done must stay low (covered by done_vec)
    repeat (6) tick();
    rd_req = 1'b1; rd_addr = 24'h000100;
    push(OwnRd, 1'b0, 1'b0, 24'h000100, 32'h0);
    run_txn(32'hDEADBEEF, 3, 3'b001, 1'b0, 1'b0);

    // cfg + wr + rd at once: cfg first, then wr (pointer not moved by cfg), then rd
    repeat (6) tick();
    cfg_req = 1'b1; cfg_we = 1'b0; cfg_ma = 8'h12; cfg_wdat = 8'h77;
    wr_req = 1'b1; wr_addr = 24'h00ABCD; wr_dat = 32'hCAFE0001;
    rd_req = 1'b1; rd_addr = 24'h00DCBA;
    push(OwnCfg, 1'b1, 1'b0, 24'h000012, 32'h00000077);
    push(OwnWr, 1'b0, 1'b1, 24'h00ABCD, 32'hCAFE0001);
    push(OwnRd, 1'b0, 1'b0, 24'h00DCBA, 32'h0);
    run_txn(32'h123456A5, 2, 3'b100, 1'b0, 1'b0);
    run_txn(32'h0,        2, 3'b010, 1'b1, 1'b0);
    run_txn(32'h87654321, 2, 3'b001, 1'b1, 1'b0);

    // en_i dropped during BUSY: done still delivered, then no new grant until re-enabled
    repeat (6) tick();
    wr_req = 1'b1; wr_addr = 24'h000400; wr_dat = 32'h0F0F0F0F;
    rd_req = 1'b1; rd_addr = 24'h000500;
    push(OwnWr, 1'b0, 1'b1, 24'h000400, 32'h0F0F0F0F);
    push(OwnRd, 1'b0, 1'b0, 24'h000500, 32'h0);
    run_txn(32'h0, 2, 3'b000, 1'b0, 1'b1);
    acc = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      acc = acc | core_start | wr_gnt | rd_gnt | cfg_gnt;
    end
    check("en_off_no_gnt", 64'(acc), 64'd0);
    check("en_off_idle", 64'(busy), 64'd0);
    en = 1'b1;
    tick();
    check("en_resume", 64'({core_start, rd_gnt}), 64'h3);
    run_txn(32'h00C0FFEE, 2, 3'b011, 1'b0, 1'b0);
    check("cfg_rdat_hold", 64'(cfg_rdat), 64'hA5);

`ifdef PSRAM_SCHED_TMO_EN
    // core never answers: abort after TC BUSY cycles, zero data, sticky error
    repeat (6) tick();
    rd_req = 1'b1; rd_addr = 24'h000040;
    push(OwnRd, 1'b0, 1'b0, 24'h000040, 32'h0);
    wait_start();
    e = sbq.pop_front();
    check("tmo_addr", 64'(core_addr), 64'(e.addr));
    rd_req = 1'b0;
    check("tmo_err_pre", 64'(err), 64'd0);
    n = 0;
    while (!rd_done && n < 60) begin
      tick();
      n++;
    end
    check("tmo_cycles", 64'(n), 64'(TC + 1));
    check("tmo_rd_dat", 64'(rd_dat), 64'd0);
    check("tmo_err", 64'(err), 64'd1);
    repeat (10) tick();
    check("tmo_err_sticky", 64'({err, busy}), 64'h2);
`endif

    // reset mid-BUSY: straight to IDLE, never a done pulse, stray core_done ignored
    repeat (6) tick();
    wr_req = 1'b1; wr_addr = 24'h55AA00; wr_dat = 32'h13572468;
    push(OwnWr, 1'b0, 1'b1, 24'h55AA00, 32'h13572468);
    wait_start();
    e = sbq.pop_front();
    check("rst_mid_addr", 64'(core_addr), 64'(e.addr));
    wr_req = 1'b0;
    repeat (2) tick();
    check("rst_mid_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_mid_idle", 64'({busy, err, core_start}), 64'd0);
    acc = 1'b0;
    core_done = 1'b1; core_rdat = 32'hFFFFFFFF;
    tick();
    core_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      acc = acc | cfg_done | wr_done | rd_done | busy;
      tick();
    end
    check("rst_mid_no_done", 64'(acc), 64'd0);
    check("rst_mid_rd_dat", 64'(rd_dat), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
